// File: rtl/npc_predict_unit.sv
// Registered next-PC generator for the IF stage: direct-mapped BTB with 2-bit
// direction counters, a speculative return address stack, and a two-state
// sequencer that inserts the MIPS delay slot before a predicted-taken target.
module npc_predict_unit #(
  parameter int          BTB_ENTRIES = 64,
  parameter int          RAS_DEPTH   = 8,
  parameter logic [31:0] RESET_PC    = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ready,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  input  logic        exp_flush,
  input  logic [31:0] epc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic [1:0]  upd_type
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDX;
  localparam int RASW = $clog2(RAS_DEPTH);
  localparam logic [RASW:0] RAS_FULL = (RASW + 1)'(RAS_DEPTH);

  localparam logic [1:0] T_COND = 2'd0;
  localparam logic [1:0] T_JUMP = 2'd1;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  typedef enum logic {S_SEQ, S_DSLOT} state_e;

  state_e      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_reg, pend_next;

  // BTB storage; valid bits are separate so reset can clear them
  logic            btb_valid_reg [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag_mem   [BTB_ENTRIES];
  logic [29:0]     btb_tgt_mem   [BTB_ENTRIES];
  logic [1:0]      btb_type_mem  [BTB_ENTRIES];
  logic [1:0]      btb_ctr_mem   [BTB_ENTRIES];

  // RAS: ptr addresses the next free slot, top of stack is ptr-1
  logic [31:0]     ras_mem [RAS_DEPTH];
  logic [RASW-1:0] ras_ptr_reg;
  logic [RASW:0]   ras_cnt_reg;
  logic [31:0]     ras_top;
  logic            ras_push, ras_pop;

  // Lookup signals
  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic [1:0]      lk_type;
  logic            lk_taken;
  logic [31:0]     lk_target;

  // Update signals
  logic [IDX-1:0]  u_idx;
  logic [TAGW-1:0] u_tag;
  logic            u_hit;
  logic            u_wr_all;
  logic            u_wr_tgt;
  logic            u_wr_ctr;
  logic [1:0]      u_ctr_new;

  // Low address bits of resolved PCs/targets are not stored
  logic unused_bits;
  assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

  assign pc_o   = pc_reg;
  assign lk_idx = pc_reg[IDX+1:2];
  assign lk_tag = pc_reg[31:IDX+2];
  assign lk_hit = btb_valid_reg[lk_idx] && (btb_tag_mem[lk_idx] == lk_tag);
  assign lk_type = btb_type_mem[lk_idx];
  assign ras_top = ras_mem[ras_ptr_reg - RASW'(1)];

  // The delay-slot PC never reports a prediction
  assign pred_taken_o = (state_reg == S_SEQ) && lk_taken;

  // Direction and target prediction for the current fetch PC
  always_comb begin
    lk_taken  = 1'b0;
    lk_target = {btb_tgt_mem[lk_idx], 2'b00};
    if (lk_hit) begin
      if (lk_type == T_COND) lk_taken = btb_ctr_mem[lk_idx][1];
      else                   lk_taken = 1'b1;
    end
    if (lk_type == T_RET) lk_target = ras_top;
  end

  // Next-PC sequencing: redirects first, then the SEQ/DSLOT step
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    pend_next  = pend_reg;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (exp_flush) begin
      pc_next    = epc;
      state_next = S_SEQ;
      pend_next  = '0;
    end else if (redirect_valid) begin
      pc_next    = redirect_pc;
      state_next = S_SEQ;
      pend_next  = '0;
    end else if (fetch_ready) begin
      case (state_reg)
        S_SEQ: begin
          pc_next = pc_reg + 32'd4;
          if (lk_taken) begin
            pend_next  = lk_target;
            state_next = S_DSLOT;
            ras_push   = (lk_type == T_CALL);
            ras_pop    = (lk_type == T_RET);
          end
        end
        S_DSLOT: begin
          pc_next    = pend_reg;
          state_next = S_SEQ;
        end
        default: state_next = S_SEQ;
      endcase
    end
  end

  // Fetch PC, sequencer state and pending target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_SEQ;
      pc_reg    <= RESET_PC;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      pend_reg  <= pend_next;
    end
  end

  // RAS pointer and occupancy; count saturates both ways, pointer always wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr_reg <= '0;
      ras_cnt_reg <= '0;
    end else if (ras_push) begin
      ras_ptr_reg <= ras_ptr_reg + RASW'(1);
      if (ras_cnt_reg != RAS_FULL) ras_cnt_reg <= ras_cnt_reg + (RASW + 1)'(1);
    end else if (ras_pop) begin
      ras_ptr_reg <= ras_ptr_reg - RASW'(1);
      if (ras_cnt_reg != '0) ras_cnt_reg <= ras_cnt_reg - (RASW + 1)'(1);
    end
  end

  // RAS entry write: return address skips the call's delay slot
  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_ptr_reg] <= pc_reg + 32'd8;
  end

  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[31:IDX+2];
  assign u_hit = btb_valid_reg[u_idx] && (btb_tag_mem[u_idx] == u_tag);

  // Decide which BTB fields a resolved instruction rewrites
  always_comb begin
    u_wr_all  = 1'b0;
    u_wr_tgt  = 1'b0;
    u_wr_ctr  = 1'b0;
    u_ctr_new = 2'd0;
    if (upd_valid) begin
      if (upd_type != T_COND) begin
        u_wr_all  = 1'b1;
        u_ctr_new = 2'd3;
      end else if (u_hit) begin
        u_wr_ctr = 1'b1;
        u_wr_tgt = upd_taken;
        if (upd_taken)
          u_ctr_new = (btb_ctr_mem[u_idx] == 2'd3) ? 2'd3 : btb_ctr_mem[u_idx] + 2'd1;
        else
          u_ctr_new = (btb_ctr_mem[u_idx] == 2'd0) ? 2'd0 : btb_ctr_mem[u_idx] - 2'd1;
      end else if (upd_taken) begin
        u_wr_all  = 1'b1;
        u_ctr_new = 2'd2;
      end
    end
  end

  // BTB payload write; lookup in the same cycle still sees the old entry
  always_ff @(posedge clk) begin
    if (u_wr_all) btb_tag_mem[u_idx] <= u_tag;
    if (u_wr_all || u_wr_tgt) begin
      btb_tgt_mem[u_idx]  <= upd_target[31:2];
      btb_type_mem[u_idx] <= upd_type;
    end
    if (u_wr_all || u_wr_ctr) btb_ctr_mem[u_idx] <= u_ctr_new;
  end

  // Per-entry valid bits, cleared by reset, set on allocation
  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  btb_valid_reg[gi] <= 1'b0;
        else if (u_wr_all && (u_idx == IDX'(gi))) btb_valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

endmodule
